// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF and MEM requester ports, pipeline stalls
// and the shared single-port RAM port of the memory arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  ram_rdata,
    output if_ack, if_rdata,
    output mem_ack, mem_rdata,
    output stall_if, stall_mem,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output ram_rdata,
    input  if_ack, if_rdata,
    input  mem_ack, mem_rdata,
    input  stall_if, stall_mem,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between fetch
// and the MEM stage; MEM wins ties, a starve count forces IF through.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT        = 3'(RAM_LAT);

  state_t            state_q, state_d;
  logic              owner_if_q, owner_if_d;
  logic              wr_q, wr_d;
  logic [3:0]        starve_q, starve_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              both_req;
  logic              if_only;
  logic              win_if;

  // Pick the winner: MEM on a tie unless IF has lost too often.
  always_comb begin
    both_req = bus.if_req & bus.mem_req;
    if_only  = bus.if_req & ~bus.mem_req;
    win_if   = 1'b0;
    unique case (1'b1)
      both_req: win_if = (starve_q == STARVE_LIM);
      if_only:  win_if = 1'b1;
      default:  win_if = 1'b0;
    endcase
  end

  // Sequence one RAM access: grant, issue, wait out latency, ack.
  always_comb begin
    state_d     = state_q;
    owner_if_d  = owner_if_q;
    wr_d        = wr_q;
    starve_d    = starve_q;
    cnt_d       = cnt_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          state_d    = ISSUE;
          owner_if_d = win_if;
          ram_en_d   = 1'b1;
          if (win_if) begin
            wr_d       = 1'b0;
            ram_addr_d = bus.if_addr;
            starve_d   = 4'd0;
          end else begin
            wr_d        = bus.mem_we;
            ram_we_d    = bus.mem_we;
            ram_addr_d  = bus.mem_addr;
            ram_wdata_d = bus.mem_wdata;
            if (bus.if_req && starve_q != STARVE_LIM) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          if (owner_if_q) begin
            if_rdata_d = bus.ram_rdata;
            if_ack_d   = 1'b1;
          end else begin
            mem_rdata_d = wr_q ? '0 : bus.ram_rdata;
            mem_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_if_q  <= 1'b0;
      wr_q        <= 1'b0;
      starve_q    <= 4'd0;
      cnt_q       <= 3'd0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_if_q  <= owner_if_d;
      wr_q        <= wr_d;
      starve_q    <= starve_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and
// a random two-requester run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int LAT1 = 1;
  localparam logic [31:0] POISON = 32'hBAD0BAD0;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1), .STARVE_MAX(SMAX)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3), .STARVE_MAX(SMAX)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 16) return 32'h00500093;
    return 32'hC0DE0000 ^ 32'(a);
  endfunction

  // RAM behind the latency-1 arbiter; data only valid one cycle.
  logic [31:0] ram1 [0:16383];
  bit          vld1 [0:16383];
  logic [31:0] pipe1 = POISON;
  always @(posedge clk) begin
    if (bus1.ram_en === 1'b1) begin
      pipe1 <= vld1[bus1.ram_addr] ? ram1[bus1.ram_addr]
                                   : init_val(int'(bus1.ram_addr));
      if (bus1.ram_we) begin
        ram1[bus1.ram_addr] <= bus1.ram_wdata;
        vld1[bus1.ram_addr] <= 1'b1;
      end
    end else begin
      pipe1 <= POISON;
    end
  end
  assign bus1.ram_rdata = pipe1;

  // RAM behind the latency-3 arbiter.
  logic [31:0] ram3 [0:255];
  bit          vld3 [0:255];
  logic [31:0] p3a = POISON;
  logic [31:0] p3b = POISON;
  logic [31:0] p3c = POISON;
  always @(posedge clk) begin
    p3b <= p3a;
    p3c <= p3b;
    if (bus3.ram_en === 1'b1) begin
      p3a <= vld3[bus3.ram_addr[7:0]] ? ram3[bus3.ram_addr[7:0]]
                                      : init_val(int'(bus3.ram_addr));
      if (bus3.ram_we) begin
        ram3[bus3.ram_addr[7:0]] <= bus3.ram_wdata;
        vld3[bus3.ram_addr[7:0]] <= 1'b1;
      end
    end else begin
      p3a <= POISON;
    end
  end
  assign bus3.ram_rdata = p3c;

  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic vec_t mk(input bit m, input bit w,
                              input logic [13:0] a,
                              input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.is_mem = m;
    v.we     = w;
    v.addr   = a;
    v.wdata  = d;
    v.exp    = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    int ens;
    if (v.is_mem) begin
      bus1.mem_req   = 1'b1;
      bus1.mem_we    = v.we;
      bus1.mem_addr  = v.addr;
      bus1.mem_wdata = v.wdata;
      if (v.we) ref_mem[int'(v.addr)] = v.wdata;
    end else begin
      bus1.if_req  = 1'b1;
      bus1.if_addr = v.addr;
    end
    n   = 0;
    ens = 0;
    while (!(v.is_mem ? bus1.mem_ack : bus1.if_ack) && n < 20) begin
      tick();
      n++;
      if (bus1.ram_en) ens++;
    end
    chk({nm, "_ack"},
        64'(v.is_mem ? bus1.mem_ack : bus1.if_ack), 64'(1));
    chk({nm, "_latency"}, 64'(n), 64'(LAT1 + 2));
    chk({nm, "_ram_en_count"}, 64'(ens), 64'(1));
    chk({nm, "_rdata"},
        64'(v.is_mem ? bus1.mem_rdata : bus1.if_rdata), 64'(v.exp));
    bus1.mem_req = 1'b0;
    bus1.if_req  = 1'b0;
    tick();
  endtask

  task automatic run3(input bit is_mem, input bit we,
                      input logic [13:0] a, input logic [31:0] wd,
                      input logic [31:0] exp, input string nm);
    int n;
    int en_at;
    if (is_mem) begin
      bus3.mem_req   = 1'b1;
      bus3.mem_we    = we;
      bus3.mem_addr  = a;
      bus3.mem_wdata = wd;
    end else begin
      bus3.if_req  = 1'b1;
      bus3.if_addr = a;
    end
    n     = 0;
    en_at = -1;
    while (!(is_mem ? bus3.mem_ack : bus3.if_ack) && n < 20) begin
      tick();
      n++;
      if (bus3.ram_en && en_at < 0) en_at = n;
    end
    chk({nm, "_en_cycle"}, 64'(en_at), 64'(1));
    chk({nm, "_latency"}, 64'(n), 64'(5));
    chk({nm, "_rdata"},
        64'(is_mem ? bus3.mem_rdata : bus3.if_rdata), 64'(exp));
    bus3.mem_req = 1'b0;
    bus3.if_req  = 1'b0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [8];
    int          n;
    int          t;
    int          next_arb;
    int          e_en;
    int          e_ia;
    int          e_ma;
    int          starve;
    bit          ip;
    bit          mp;
    bit          mwe;
    bit          win;
    bit          e_we;
    logic [13:0] ia;
    logic [13:0] ma;
    logic [13:0] e_addr;
    logic [31:0] mwd;
    logic [31:0] e_wd;
    logic [31:0] e_id;
    logic [31:0] e_md;

    tbl[0] = mk(1, 1, 14'h020, 32'hDEADBEEF, 32'h0);
    tbl[1] = mk(1, 0, 14'h020, 32'h0, 32'hDEADBEEF);
    tbl[2] = mk(0, 0, 14'h020, 32'h0, 32'hDEADBEEF);
    tbl[3] = mk(1, 1, 14'h3FFF, 32'h12345678, 32'h0);
    tbl[4] = mk(0, 0, 14'h3FFF, 32'h0, 32'h12345678);
    tbl[5] = mk(1, 0, 14'h000, 32'h0, init_val(0));
    tbl[6] = mk(1, 1, 14'h000, 32'hFFFFFFFF, 32'h0);
    tbl[7] = mk(0, 0, 14'h000, 32'h0, 32'hFFFFFFFF);

    rst            = 1'b0;
    bus1.if_req    = 1'b1;
    bus1.if_addr   = 14'd6;
    bus1.mem_req   = 1'b1;
    bus1.mem_we    = 1'b0;
    bus1.mem_addr  = 14'd5;
    bus1.mem_wdata = 32'h0;
    bus3.if_req    = 1'b0;
    bus3.if_addr   = 14'd0;
    bus3.mem_req   = 1'b0;
    bus3.mem_we    = 1'b0;
    bus3.mem_addr  = 14'd0;
    bus3.mem_wdata = 32'h0;

    // Reset held with both requests pending.
    tick();
    tick();
    chk("rst_ram_en", 64'(bus1.ram_en), 64'(0));
    chk("rst_if_ack", 64'(bus1.if_ack), 64'(0));
    chk("rst_mem_ack", 64'(bus1.mem_ack), 64'(0));
    chk("rst_if_rdata", 64'(bus1.if_rdata), 64'(0));
    chk("rst_mem_rdata", 64'(bus1.mem_rdata), 64'(0));
    chk("rst_stall_mem", 64'(bus1.stall_mem), 64'(1));
    chk("rst_lat3_ram_en", 64'(bus3.ram_en), 64'(0));
    rst = 1'b1;
    tick();
    chk("rst_first_en", 64'(bus1.ram_en), 64'(1));
    chk("rst_first_addr", 64'(bus1.ram_addr), 64'(5));
    chk("rst_first_we", 64'(bus1.ram_we), 64'(0));
    n = 0;
    while (!bus1.mem_ack && n < 10) begin tick(); n++; end
    chk("rst_mem_ack_seen", 64'(bus1.mem_ack), 64'(1));
    chk("rst_mem_rdata_val", 64'(bus1.mem_rdata), 64'(init_val(5)));
    bus1.mem_req = 1'b0;
    n = 0;
    while (!bus1.if_ack && n < 10) begin tick(); n++; end
    chk("rst_if_ack_seen", 64'(bus1.if_ack), 64'(1));
    chk("rst_if_rdata_val", 64'(bus1.if_rdata), 64'(init_val(6)));
    bus1.if_req = 1'b0;
    tick();

    // IF-only boot read, cycle by cycle.
    bus1.if_req  = 1'b1;
    bus1.if_addr = 14'h010;
    #1;
    chk("if2_stall_c0", 64'(bus1.stall_if), 64'(1));
    tick();
    chk("if2_en_c1", 64'(bus1.ram_en), 64'(1));
    chk("if2_addr_c1", 64'(bus1.ram_addr), 64'(16));
    chk("if2_we_c1", 64'(bus1.ram_we), 64'(0));
    chk("if2_stall_c1", 64'(bus1.stall_if), 64'(1));
    tick();
    chk("if2_en_c2", 64'(bus1.ram_en), 64'(0));
    chk("if2_ack_c2", 64'(bus1.if_ack), 64'(0));
    chk("if2_stall_c2", 64'(bus1.stall_if), 64'(1));
    tick();
    chk("if2_ack_c3", 64'(bus1.if_ack), 64'(1));
    chk("if2_rdata_c3", 64'(bus1.if_rdata), 64'(32'h00500093));
    chk("if2_stall_c3", 64'(bus1.stall_if), 64'(0));
    bus1.if_req = 1'b0;
    tick();
    chk("if2_ack_c4", 64'(bus1.if_ack), 64'(0));

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
    end

    // MEM drops its request right after issue; ack still arrives.
    bus1.mem_req  = 1'b1;
    bus1.mem_we   = 1'b0;
    bus1.mem_addr = 14'h020;
    tick();
    bus1.mem_req = 1'b0;
    #1;
    chk("drop_en", 64'(bus1.ram_en), 64'(1));
    chk("drop_stall", 64'(bus1.stall_mem), 64'(0));
    tick();
    chk("drop_ack_c2", 64'(bus1.mem_ack), 64'(0));
    tick();
    chk("drop_ack_c3", 64'(bus1.mem_ack), 64'(1));
    chk("drop_rdata", 64'(bus1.mem_rdata), 64'(32'hDEADBEEF));
    tick();
    chk("drop_ack_c4", 64'(bus1.mem_ack), 64'(0));
    chk("drop_en_c4", 64'(bus1.ram_en), 64'(0));

    // Both held: MEM x4 then IF, twice.
    bus1.if_req   = 1'b1;
    bus1.if_addr  = 14'h010;
    bus1.mem_req  = 1'b1;
    bus1.mem_we   = 1'b0;
    bus1.mem_addr = 14'h020;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      while (!(bus1.if_ack || bus1.mem_ack) && n < 20) begin
        tick();
        n++;
      end
      chk("starve_grant",
          64'({bus1.if_ack, bus1.mem_ack}),
          64'((g % 5 == 4) ? 2'b10 : 2'b01));
      chk("starve_gap", 64'(n), 64'(LAT1 + 2));
      if (g % 5 == 4) begin
        chk("starve_if_data", 64'(bus1.if_rdata), 64'(32'h00500093));
      end else begin
        chk("starve_mem_data", 64'(bus1.mem_rdata), 64'(32'hDEADBEEF));
      end
      if (g == 9) begin
        bus1.if_req  = 1'b0;
        bus1.mem_req = 1'b0;
      end
      tick();
    end

    // Latency-3 RAM: ack five cycles after request.
    run3(1, 1, 14'd7, 32'hCAFEF00D, 32'h0, "lat3_wr");
    run3(1, 0, 14'd7, 32'h0, 32'hCAFEF00D, "lat3_rd");
    run3(0, 0, 14'd9, 32'h0, init_val(9), "lat3_if");

    // Reset during WAIT aborts the fetch.
    bus1.if_req  = 1'b1;
    bus1.if_addr = 14'h010;
    tick();
    chk("abort_en", 64'(bus1.ram_en), 64'(1));
    tick();
    rst         = 1'b0;
    bus1.if_req = 1'b0;
    tick();
    chk("abort_no_ack", 64'(bus1.if_ack), 64'(0));
    chk("abort_en_low", 64'(bus1.ram_en), 64'(0));
    chk("abort_rdata_clr", 64'(bus1.if_rdata), 64'(0));
    rst         = 1'b1;
    bus1.if_req = 1'b1;
    tick();
    chk("abort_idle_en", 64'(bus1.ram_en), 64'(1));
    chk("abort_no_ack_c4", 64'(bus1.if_ack), 64'(0));
    tick();
    chk("abort_no_ack_c5", 64'(bus1.if_ack), 64'(0));
    tick();
    chk("abort_retry_ack", 64'(bus1.if_ack), 64'(1));
    chk("abort_retry_data", 64'(bus1.if_rdata), 64'(32'h00500093));
    bus1.if_req = 1'b0;
    tick();

    // Random traffic against a transaction-level timing model.
    t        = 0;
    next_arb = 0;
    e_en     = -1;
    e_ia     = -1;
    e_ma     = -1;
    starve   = 0;
    ip       = 1'b0;
    mp       = 1'b0;
    mwe      = 1'b0;
    ia       = 14'd0;
    ma       = 14'd0;
    mwd      = 32'h0;
    e_addr   = 14'd0;
    e_we     = 1'b0;
    e_wd     = 32'h0;
    e_id     = 32'h0;
    e_md     = 32'h0;
    for (int i = 0; i < 800; i++) begin
      chk("rnd_if_ack", 64'(bus1.if_ack), 64'(t == e_ia));
      chk("rnd_mem_ack", 64'(bus1.mem_ack), 64'(t == e_ma));
      chk("rnd_ram_en", 64'(bus1.ram_en), 64'(t == e_en));
      chk("rnd_stall_if", 64'(bus1.stall_if), 64'(ip && t != e_ia));
      chk("rnd_stall_mem", 64'(bus1.stall_mem), 64'(mp && t != e_ma));
      if (t == e_ia) chk("rnd_if_rdata", 64'(bus1.if_rdata), 64'(e_id));
      if (t == e_ma) chk("rnd_mem_rdata", 64'(bus1.mem_rdata), 64'(e_md));
      if (t == e_en) begin
        chk("rnd_ram_addr", 64'(bus1.ram_addr), 64'(e_addr));
        chk("rnd_ram_we", 64'(bus1.ram_we), 64'(e_we));
        if (e_we) chk("rnd_ram_wdata", 64'(bus1.ram_wdata), 64'(e_wd));
      end
      if (t == e_ia) begin
        ip = 1'b0;
      end else if (!ip && $urandom_range(2) == 0) begin
        ip = 1'b1;
        ia = 14'($urandom_range(31));
      end
      if (t == e_ma) begin
        mp = 1'b0;
      end else if (!mp && $urandom_range(2) == 0) begin
        mp  = 1'b1;
        mwe = 1'($urandom_range(1));
        ma  = 14'($urandom_range(31));
        mwd = $urandom;
      end
      bus1.if_req    = ip;
      bus1.if_addr   = ia;
      bus1.mem_req   = mp;
      bus1.mem_we    = mwe;
      bus1.mem_addr  = ma;
      bus1.mem_wdata = mwd;
      if (t == next_arb) begin
        if (ip || mp) begin
          win = ip && (!mp || starve == SMAX);
          if (win) begin
            starve = 0;
            e_ia   = t + LAT1 + 2;
            e_addr = ia;
            e_we   = 1'b0;
            e_id   = ref_rd(int'(ia));
          end else begin
            if (ip) starve = (starve < SMAX) ? starve + 1 : SMAX;
            e_ma   = t + LAT1 + 2;
            e_addr = ma;
            e_we   = mwe;
            e_wd   = mwd;
            e_md   = mwe ? 32'h0 : ref_rd(int'(ma));
            if (mwe) ref_mem[int'(ma)] = mwd;
          end
          e_en     = t + 1;
          next_arb = t + LAT1 + 3;
        end else begin
          next_arb = t + 1;
        end
      end
      tick();
      t++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
